// File: rtl/pc_frame_decoder.sv
// Assembles 3-byte PC link frames (addr, LSB, MSB) into 16-bit register writes with a self-clearing request word.
// Optional partial-frame timeout enabled by defining PC_FRAME_TIMEOUT_EN.
module pc_frame_decoder #(
  parameter int DATA_WIDTH     = 16,
  parameter int NUM_REGS       = 8,
  parameter int RQST_ADDR      = 0,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [7:0]                     rx_data,
  input  logic                           rx_valid,
  output logic                           rx_ready,
  output logic [DATA_WIDTH-1:0]          request_reg_data,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic                           wr_strobe_o,
  output logic [7:0]                     wr_addr_o,
  output logic                           bad_addr_o,
  output logic                           timeout_o
);

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  // A frame carries exactly two data bytes, so only a 16-bit bank is meaningful.
  if (DATA_WIDTH != 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("pc_frame_decoder: DATA_WIDTH must be 16 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GET_LSB = 2'd1,
    GET_MSB = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [7:0]            addr_q, addr_d;
  logic [7:0]            lsb_q, lsb_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [DATA_WIDTH-1:0] request_q, request_d;
  logic                  wr_strobe_q, wr_strobe_d;
  logic [7:0]            wr_addr_q, wr_addr_d;
  logic                  bad_addr_q, bad_addr_d;
  logic                  timeout_q, timeout_d;
  logic                  accept_s;
  logic [15:0]           data_s;

`ifdef PC_FRAME_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  assign rx_ready = 1'b1;
  assign accept_s = rx_valid & rx_ready;
  assign data_s   = {rx_data, lsb_q};

  // Next-state, commit and pulse generation.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    lsb_d       = lsb_q;
    regs_d      = regs_q;
    request_d   = '0;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    bad_addr_d  = 1'b0;
    timeout_d   = 1'b0;
`ifdef PC_FRAME_TIMEOUT_EN
    cnt_d       = '0;
`endif
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          addr_d  = rx_data;
          state_d = GET_LSB;
        end else begin
          state_d = IDLE;
        end
      end
      GET_LSB, GET_MSB: begin
        if (accept_s) begin
          if (state_q == GET_LSB) begin
            lsb_d   = rx_data;
            state_d = GET_MSB;
          end else begin
            state_d = IDLE;
            if (int'(addr_q) < NUM_REGS) begin
              wr_strobe_d = 1'b1;
              wr_addr_d   = addr_q;
              if (int'(addr_q) == RQST_ADDR) begin
                request_d = data_s;
              end else begin
                regs_d[addr_q[AW-1:0]] = data_s;
              end
            end else begin
              bad_addr_d = 1'b1;
            end
          end
        end else begin
`ifdef PC_FRAME_TIMEOUT_EN
          // Expiry only on an idle cycle: a byte in the same cycle keeps the frame alive.
          if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            state_d   = IDLE;
            timeout_d = 1'b1;
            addr_d    = 8'h00;
            lsb_d     = 8'h00;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`else
          state_d = state_q;
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset wins over any byte presented in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= 8'h00;
      lsb_q       <= 8'h00;
      regs_q      <= '{default: '0};
      request_q   <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 8'h00;
      bad_addr_q  <= 1'b0;
      timeout_q   <= 1'b0;
`ifdef PC_FRAME_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      lsb_q       <= lsb_d;
      regs_q      <= regs_d;
      request_q   <= request_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      bad_addr_q  <= bad_addr_d;
      timeout_q   <= timeout_d;
`ifdef PC_FRAME_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  // Flatten the bank: reg k at bits [k*DATA_WIDTH +: DATA_WIDTH].
  always_comb begin
    regs_o = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_o[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end
  end

  assign request_reg_data = request_q;
  assign wr_strobe_o      = wr_strobe_q;
  assign wr_addr_o        = wr_addr_q;
  assign bad_addr_o       = bad_addr_q;
  assign timeout_o        = timeout_q;

endmodule

// File: tb/tb_pc_frame_decoder.sv
// Directed, scoreboard-based bench for pc_frame_decoder (timeout tests when PC_FRAME_TIMEOUT_EN is defined).
module tb_pc_frame_decoder;

  localparam int NR = 8;
  localparam int DW = 16;
  localparam int TO = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic [DW-1:0]    request_reg_data;
  logic [NR*DW-1:0] regs_o;
  logic             wr_strobe_o;
  logic [7:0]       wr_addr_o;
  logic             bad_addr_o;
  logic             timeout_o;

  int total = 0;
  int bad   = 0;

  // Event record: {wr_strobe, bad_addr, timeout, request_word, wr_addr}
  logic [26:0] exp_q [$];
  logic [26:0] mon_obs;
  logic [26:0] mon_exp;
  logic [15:0] regs_m [NR];
  logic [7:0]  last_addr;

  pc_frame_decoder #(
    .DATA_WIDTH(DW), .NUM_REGS(NR), .RQST_ADDR(0), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .request_reg_data(request_reg_data), .regs_o(regs_o), .wr_strobe_o(wr_strobe_o),
    .wr_addr_o(wr_addr_o), .bad_addr_o(bad_addr_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pack_m();
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < NR; i++) v[i*DW +: DW] = regs_m[i];
    return v;
  endfunction

  // Pop one expected event whenever the DUT shows any write/bad/timeout/request activity.
  always @(negedge clk) begin
    if (rst === 1'b0 && (wr_strobe_o || bad_addr_o || timeout_o || request_reg_data != 16'h0000)) begin
      mon_obs = {wr_strobe_o, bad_addr_o, timeout_o, request_reg_data, wr_addr_o};
      if (exp_q.size() == 0) begin
        check("unexpected_event", 128'(mon_obs), 128'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("event", 128'(mon_obs), 128'(mon_exp));
      end
    end
  end

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_commit(input logic [7:0] a, input logic [15:0] d);
    if (a < 8'(NR)) begin
      if (a == 8'h00) begin
        exp_q.push_back({1'b1, 1'b0, 1'b0, d, a});
      end else begin
        exp_q.push_back({1'b1, 1'b0, 1'b0, 16'h0000, a});
        regs_m[a[2:0]] = d;
      end
      last_addr = a;
    end else begin
      exp_q.push_back({1'b0, 1'b1, 1'b0, 16'h0000, last_addr});
    end
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] lo, input logic [7:0] hi);
    send(a);
    send(lo);
    push_commit(a, {hi, lo});
    send(hi);
    check("regs_after_frame", regs_o, pack_m());
  endtask

  initial begin
    rst       = 1'b1;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    last_addr = 8'h00;
    for (int i = 0; i < NR; i++) regs_m[i] = 16'h0000;
    idle(2);
    check("reset_outputs", {regs_o, request_reg_data, wr_strobe_o, wr_addr_o, bad_addr_o, timeout_o},
          {pack_m(), 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0});
    rst = 1'b0;
    idle(1);
    check("rx_ready", 128'(rx_ready), 128'd1);

    // Config write
    frame(8'h03, 8'h34, 8'h12);
    check("reg3", 128'(regs_o[63:48]), 128'h1234);
    check("wr_addr", 128'(wr_addr_o), 128'h03);
    idle(1);
    check("strobe_drop", 128'(wr_strobe_o), 128'd0);

    // Request pulse
    frame(8'h00, 8'h01, 8'h00);
    check("request_word", 128'(request_reg_data), 128'h0001);
    idle(1);
    check("request_clear", 128'(request_reg_data), 128'd0);
    check("reg0_zero", 128'(regs_o[15:0]), 128'd0);

    // Full-rate back-to-back frames, incl. top valid address and a request
    frame(8'h05, 8'hCD, 8'hAB);
    frame(8'h00, 8'h02, 8'h80);
    frame(8'h07, 8'h11, 8'h22);
    frame(8'h01, 8'h5A, 8'hA5);

    // Bad addresses: just past the bank and far out of range
    frame(8'h09, 8'hFF, 8'hFF);
    frame(8'h08, 8'h12, 8'h34);
    frame(8'hFF, 8'h00, 8'h01);
    idle(1);
    check("bad_drop", 128'(bad_addr_o), 128'd0);

`ifdef PC_FRAME_TIMEOUT_EN
    // Partial frame abandoned after TO idle cycles
    send(8'h02);
    send(8'hAA);
    exp_q.push_back({1'b0, 1'b0, 1'b1, 16'h0000, last_addr});
    idle(TO - 1);
    check("timeout_early", 128'(timeout_o), 128'd0);
    idle(1);
    check("timeout_pulse", 128'(timeout_o), 128'd1);
    // Byte in the pulse cycle starts a new frame
    frame(8'h02, 8'h55, 8'h66);
    check("reg2", 128'(regs_o[47:32]), 128'h6655);

    // Byte on the expiry cycle wins
    send(8'h04);
    send(8'h77);
    idle(TO - 1);
    push_commit(8'h04, 16'h8877);
    send(8'h88);
    check("reg4_boundary", 128'(regs_o[79:64]), 128'h8877);
`else
    // Without the timeout a partial frame waits indefinitely
    send(8'h04);
    send(8'h77);
    idle(TO + 5);
    push_commit(8'h04, 16'h8877);
    send(8'h88);
    check("reg4_no_timeout", 128'(regs_o[79:64]), 128'h8877);
`endif

    // Reset mid-frame, with a byte presented during reset
    send(8'h01);
    send(8'h11);
    rx_data  = 8'h05;
    rx_valid = 1'b1;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    for (int i = 0; i < NR; i++) regs_m[i] = 16'h0000;
    last_addr = 8'h00;
    check("post_reset_outputs", {regs_o, request_reg_data, wr_strobe_o, wr_addr_o, bad_addr_o, timeout_o},
          {pack_m(), 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0});
    frame(8'h01, 8'h22, 8'h33);
    check("reg1_after_reset", 128'(regs_o[31:16]), 128'h3322);
    check("wr_addr_after_reset", 128'(wr_addr_o), 128'h01);

    idle(3);
    check("all_events_seen", 128'(exp_q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
